// File: rtl/expr_eval.sv
// -----------------------------------------------------------------------------
// expr_eval
//
// Evaluates a streamed ASCII expression of the form digit (op digit)*.
// The operators are '+' and '*', and '*' binds tighter than '+'.
// The running value of the expression (sum + current term) is presented after
// every accepted digit.
//
// The value is kept as two registers:
//   sum  - the total of all completed additive terms
//   term - the multiplicative term currently being built
//
// Optional feature (macro EXPR_SUB_EN):
//   When defined, '-' becomes a third operator with '+' precedence.
//   Values are then treated as signed two's complement, and ovf uses
//   signed-overflow rules.
//   When undefined, '-' is an invalid character and pend_op is a single bit.
//
// Ports:
//   clk          rising-edge clock
//   clr_n        asynchronous active-low reset
//   in           ASCII character
//   in_valid     character strobe; in is consumed only when high
//   result       sum + current term (WIDTH bits, wraps)
//   result_valid high while the accepted prefix ends in a digit
//   err          sticky grammar-violation flag
//   ovf          sticky arithmetic-wrap flag
// -----------------------------------------------------------------------------
module expr_eval #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [7:0]       in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             err,
    output logic             ovf
);

`ifdef EXPR_SUB_EN
    localparam int OPW = 2;
    localparam logic [OPW-1:0] OP_SUB = OPW'(2);
`else
    localparam int OPW = 1;
`endif
    localparam logic [OPW-1:0] OP_ADD = '0;
    localparam logic [OPW-1:0] OP_MUL = OPW'(1);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        OPND = 4'b0010,
        OPR  = 4'b0100,
        ERR  = 4'b1000
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] term;
    logic [OPW-1:0]   pend_op;

    logic               is_digit;
    logic [WIDTH-1:0]   digit;
    logic [2*WIDTH-1:0] mul_full;
    logic               mul_ovf;
    logic [WIDTH-1:0]   new_term;
    logic               new_term_ovf;
    logic [WIDTH-1:0]   sum_term;
    logic               sum_term_ovf;
    logic [WIDTH-1:0]   res_sum;
    logic               res_ovf;

    // Overflow test for a + b.
    // Unsigned mode uses the carry out of a WIDTH+1-bit add.
    // Signed mode checks for two like-signed operands giving an unlike-signed sum.
    function automatic logic add_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef EXPR_SUB_EN
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
`else
        return s[WIDTH];
`endif
    endfunction

    // '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
    assign is_digit = (in >= 8'h30) && (in <= 8'h39);
    assign digit    = {{(WIDTH-4){1'b0}}, in[3:0]};

`ifdef EXPR_SUB_EN
    // The digit is never negative.
    // A sign-extended term times a zero-extended digit gives the exact signed
    // product in 2*WIDTH bits.
    assign mul_full = {{WIDTH{term[WIDTH-1]}}, term} * {{WIDTH{1'b0}}, digit};
    // The product fits only if the upper WIDTH+1 bits are all copies of the
    // sign bit.
    assign mul_ovf  = !((mul_full[2*WIDTH-1:WIDTH-1] == '0) ||
                        (mul_full[2*WIDTH-1:WIDTH-1] == '1));
`else
    assign mul_full = {{WIDTH{1'b0}}, term} * {{WIDTH{1'b0}}, digit};
    assign mul_ovf  = |mul_full[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        new_term     = digit;
        new_term_ovf = 1'b0;
        if (pend_op == OP_MUL) begin
            new_term     = mul_full[WIDTH-1:0];
            new_term_ovf = mul_ovf;
        end
`ifdef EXPR_SUB_EN
        else if (pend_op == OP_SUB) begin
            new_term = '0 - digit;
        end
`endif
    end

    assign sum_term     = sum + term;
    assign sum_term_ovf = add_ovf(sum, term);
    assign res_sum      = sum + new_term;
    assign res_ovf      = add_ovf(sum, new_term);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state        <= IDLE;
            sum          <= '0;
            term         <= '0;
            pend_op      <= OP_ADD;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            ovf          <= 1'b0;
        end else if (in_valid) begin
            case (state)
                IDLE: begin
                    // Anything before the first digit is skipped.
                    if (is_digit) begin
                        sum          <= '0;
                        term         <= digit;
                        result       <= digit;
                        result_valid <= 1'b1;
                        state        <= OPND;
                    end
                end
                OPND: begin
                    if (in == 8'h2B) begin          // '+' closes the current term
                        sum          <= sum_term;
                        ovf          <= ovf | sum_term_ovf;
                        pend_op      <= OP_ADD;
                        result_valid <= 1'b0;
                        state        <= OPR;
                    end else if (in == 8'h2A) begin // '*' keeps building the term
                        pend_op      <= OP_MUL;
                        result_valid <= 1'b0;
                        state        <= OPR;
                    end
`ifdef EXPR_SUB_EN
                    else if (in == 8'h2D) begin     // '-' closes the term; next digit negated
                        sum          <= sum_term;
                        ovf          <= ovf | sum_term_ovf;
                        pend_op      <= OP_SUB;
                        result_valid <= 1'b0;
                        state        <= OPR;
                    end
`endif
                    else begin
                        err          <= 1'b1;
                        result_valid <= 1'b0;
                        state        <= ERR;
                    end
                end
                OPR: begin
                    if (is_digit) begin
                        term         <= new_term;
                        result       <= res_sum;
                        result_valid <= 1'b1;
                        ovf          <= ovf | new_term_ovf | res_ovf;
                        state        <= OPND;
                    end else begin
                        err          <= 1'b1;
                        result_valid <= 1'b0;
                        state        <= ERR;
                    end
                end
                ERR: begin
                    // Absorb everything until reset.
                end
                default: begin
                    err          <= 1'b1;
                    result_valid <= 1'b0;
                    state        <= ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_expr_eval.sv
// -----------------------------------------------------------------------------
// tb_expr_eval
//
// Directed testbench for expr_eval.
// Two instances share one character stream:
//   dut32 - WIDTH=32
//   dut8  - WIDTH=8, used for the wrap/overflow cases
// Inputs change on the falling clock edge.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_expr_eval;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [7:0] in = 8'h00;
    logic       in_valid = 1'b0;

    logic [31:0] r32;
    logic        v32, e32, o32;
    logic [7:0]  r8;
    logic        v8, e8, o8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    expr_eval #(.WIDTH(32)) dut32 (
        .clk(clk), .clr_n(clr_n), .in(in), .in_valid(in_valid),
        .result(r32), .result_valid(v32), .err(e32), .ovf(o32)
    );

    expr_eval #(.WIDTH(8)) dut8 (
        .clk(clk), .clr_n(clr_n), .in(in), .in_valid(in_valid),
        .result(r8), .result_valid(v8), .err(e8), .ovf(o8)
    );

    // Apply one character with in_valid=1.
    // Returns 1 time unit after the rising edge that accepts it.
    task automatic step(input byte c);
        @(negedge clk);
        in       = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        $display("char '%c' -> r32=%0d v=%0b err=%0b ovf=%0b | r8=%0d ovf8=%0b",
                 c, r32, v32, e32, o32, r8, o8);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0;
        clr_n    = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({r32, v32, e32, o32} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset32: got r=%0h v=%0b e=%0b o=%0b want all 0", r32, v32, e32, o32);
        end
        vectors++;
        if ({r8, v8, e8, o8} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset8: got r=%0h v=%0b e=%0b o=%0b want all 0", r8, v8, e8, o8);
        end
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_precedence();
        string       s = "2+3*4";
        logic [31:0] er[5] = '{32'd2, 32'd0, 32'd5, 32'd0, 32'd14};
        logic        ev[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(s[i]);
            vectors++;
            if (v32 !== ev[i]) begin
                miscompares++;
                $display("FAIL prec_valid[%0d]: got %0b want %0b", i, v32, ev[i]);
            end
            if (ev[i]) begin
                vectors++;
                if (r32 !== er[i]) begin
                    miscompares++;
                    $display("FAIL prec_result[%0d]: got %0d want %0d", i, r32, er[i]);
                end
            end
        end
        vectors++;
        if (e32 !== 1'b0) begin
            miscompares++;
            $display("FAIL prec_err: got %0b want 0", e32);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        step("2");
        step("+");
        step("3");
        @(negedge clk);
        in_valid = 1'b0;
        in       = "*";
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (r32 !== 32'd5 || v32 !== 1'b1) begin
                miscompares++;
                $display("FAIL stall[%0d]: got r=%0d v=%0b want r=5 v=1", i, r32, v32);
            end
        end
        step("*");
        step("4");
        vectors++;
        if (r32 !== 32'd14 || v32 !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_final: got r=%0d v=%0b want r=14 v=1", r32, v32);
        end
    endtask

    task automatic test_error();
        apply_reset();
        step("9");
        step("+");
        step("*");
        vectors++;
        if (e32 !== 1'b1 || v32 !== 1'b0 || r32 !== 32'd9) begin
            miscompares++;
            $display("FAIL err_entry: got e=%0b v=%0b r=%0d want e=1 v=0 r=9", e32, v32, r32);
        end
        step("5");
        step("+");
        vectors++;
        if (e32 !== 1'b1 || v32 !== 1'b0 || r32 !== 32'd9) begin
            miscompares++;
            $display("FAIL err_absorb: got e=%0b v=%0b r=%0d want e=1 v=0 r=9", e32, v32, r32);
        end
        // Assert clr_n between clock edges and check that outputs clear without an edge.
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        vectors++;
        if ({r32, v32, e32, o32} !== 35'd0) begin
            miscompares++;
            $display("FAIL async_clear: got r=%0d v=%0b e=%0b o=%0b want all 0", r32, v32, e32, o32);
        end
        #1;
        clr_n = 1'b1;
    endtask

    task automatic test_leading_junk();
        string       s = "ab7*8";
        logic [31:0] er[5] = '{32'd0, 32'd0, 32'd7, 32'd0, 32'd56};
        logic        ev[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(s[i]);
            vectors++;
            if (v32 !== ev[i] || e32 !== 1'b0) begin
                miscompares++;
                $display("FAIL junk_valid[%0d]: got v=%0b e=%0b want v=%0b e=0", i, v32, e32, ev[i]);
            end
            if (ev[i]) begin
                vectors++;
                if (r32 !== er[i]) begin
                    miscompares++;
                    $display("FAIL junk_result[%0d]: got %0d want %0d", i, r32, er[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        string      s = "9*9*9+1";
        logic [7:0] er[7] = '{8'd9, 8'd0, 8'd81, 8'd0, 8'd217, 8'd0, 8'd218};
        logic       ev[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       eo[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            step(s[i]);
            vectors++;
            if (o8 !== eo[i] || v8 !== ev[i]) begin
                miscompares++;
                $display("FAIL ovf8_flags[%0d]: got ovf=%0b v=%0b want ovf=%0b v=%0b", i, o8, v8, eo[i], ev[i]);
            end
            if (ev[i]) begin
                vectors++;
                if (r8 !== er[i]) begin
                    miscompares++;
                    $display("FAIL ovf8_result[%0d]: got %0d want %0d", i, r8, er[i]);
                end
            end
            if (i == 4) begin
                vectors++;
                if (r32 !== 32'd729 || o32 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wide_no_ovf: got r=%0d ovf=%0b want r=729 ovf=0", r32, o32);
                end
            end
        end
    endtask

    task automatic test_sub();
        apply_reset();
        step("3");
        vectors++;
        if (r32 !== 32'd3 || v32 !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_first: got r=%0d v=%0b want r=3 v=1", r32, v32);
        end
        step("-");
`ifdef EXPR_SUB_EN
        vectors++;
        if (e32 !== 1'b0 || v32 !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_op: got e=%0b v=%0b want e=0 v=0", e32, v32);
        end
        step("8");
        vectors++;
        if (r32 !== 32'hFFFF_FFFB || v32 !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_neg: got r=%0h v=%0b want r=fffffffb v=1", r32, v32);
        end
        step("*");
        step("2");
        vectors++;
        if (r32 !== 32'hFFFF_FFF3 || o32 !== 1'b0 || e32 !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_mul: got r=%0h o=%0b e=%0b want r=fffffff3 o=0 e=0", r32, o32, e32);
        end
`else
        vectors++;
        if (e32 !== 1'b1 || v32 !== 1'b0 || r32 !== 32'd3) begin
            miscompares++;
            $display("FAIL minus_invalid: got e=%0b v=%0b r=%0d want e=1 v=0 r=3", e32, v32, r32);
        end
        step("8");
        vectors++;
        if (e32 !== 1'b1 || v32 !== 1'b0) begin
            miscompares++;
            $display("FAIL minus_absorb: got e=%0b v=%0b want e=1 v=0", e32, v32);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_precedence();
        test_stall();
        test_error();
        test_leading_junk();
        test_overflow();
        test_sub();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
